// File: rtl/muldiv_unit.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// muldiv_unit -- iterative 32-bit multiply / divide unit with HI/LO registers.
//
// Multiply is radix-2 shift-add (one multiplier bit per cycle). Divide is
// restoring division (one quotient bit per cycle). Signed operations run on
// magnitudes, and the signs are applied in a final FIXUP cycle. Every accepted
// operation takes 33 cycles from start to done.
//
// Ports:
//   clk       in   sole clock, rising edge
//   rst       in   asynchronous reset, active low
//   start     in   request a new operation (sampled only when idle)
//   op        in   `Mult / `Multu / `Div / `Divu (other codes are ignored)
//   src_a     in   multiplicand / dividend
//   src_b     in   multiplier / divisor
//   flush     in   abort the running operation; suppresses start when idle
//   busy      out  operation in progress (CALC or FIXUP)
//   done      out  one-cycle pulse when hi/lo are written
//   div_zero  out  one-cycle pulse with done for a divide by zero
//   hi, lo    out  HI / LO result registers
// ---------------------------------------------------------------------------

`ifndef ALUOpWidth
`define ALUOpWidth 4
`endif
`ifndef Mult
`define Mult  4'd8
`endif
`ifndef Multu
`define Multu 4'd9
`endif
`ifndef Div
`define Div   4'd10
`endif
`ifndef Divu
`define Divu  4'd11
`endif

module muldiv_unit (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [`ALUOpWidth-1:0] op,
  input  logic [31:0]            src_a,
  input  logic [31:0]            src_b,
  input  logic                   flush,
  output logic                   busy,
  output logic                   done,
  output logic                   div_zero,
  output logic [31:0]            hi,
  output logic [31:0]            lo
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;   // product / quotient must be negated
  logic        neg_rem_q, neg_rem_d;   // remainder must be negated
  logic        b_zero_q, b_zero_d;
  logic [31:0] a_raw_q, a_raw_d;       // unmodified dividend for divide-by-zero
  logic [31:0] m_q, m_d;               // |multiplicand| or |divisor|
  logic [63:0] acc_q, acc_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        div_zero_q, div_zero_d;

  // Operation decode (only meaningful while idle).
  logic        op_valid, op_signed, op_div;
  logic [31:0] a_abs, b_abs;

  // Iteration datapath.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_pr;
  logic [32:0] div_diff;
  logic        div_ok;
  logic [63:0] div_next;

  // Sign-corrected results.
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  always_comb begin
    op_valid  = (op == `Mult) || (op == `Multu) || (op == `Div) || (op == `Divu);
    op_signed = (op == `Mult) || (op == `Div);
    op_div    = (op == `Div)  || (op == `Divu);
    // Negating 0x80000000 yields 0x80000000, which is the correct magnitude
    // when read as unsigned.
    a_abs     = (op_signed && src_a[31]) ? (32'd0 - src_a) : src_a;
    b_abs     = (op_signed && src_b[31]) ? (32'd0 - src_b) : src_b;
  end

  // Shift-add step: acc = {partial product, remaining multiplier bits}.
  // The 33-bit sum keeps the carry, which shifts down into bit 63.
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, m_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};
  end

  // Restoring step: acc = {partial remainder, dividend bits / quotient bits}.
  // The shifted remainder needs 33 bits; a clear top bit of the difference
  // means the trial subtract fits and the quotient bit is 1.
  always_comb begin
    div_pr   = {acc_q[63:32], acc_q[31]};
    div_diff = div_pr - {1'b0, m_q};
    div_ok   = ~div_diff[32];
    div_next = {(div_ok ? div_diff[31:0] : div_pr[31:0]), acc_q[30:0], div_ok};
  end

  always_comb begin
    prod_fix = neg_res_q ? (64'd0 - acc_q) : acc_q;
    quo_fix  = neg_res_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    rem_fix  = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    b_zero_d   = b_zero_q;
    a_raw_d    = a_raw_q;
    m_d        = m_q;
    acc_d      = acc_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !flush && op_valid) begin
          state_d   = ST_CALC;
          cnt_d     = 5'd0;
          is_div_d  = op_div;
          neg_res_d = op_signed && (src_a[31] ^ src_b[31]);
          neg_rem_d = op_signed && src_a[31];
          b_zero_d  = (src_b == 32'd0);
          a_raw_d   = src_a;
          if (op_div) begin
            m_d   = b_abs;
            acc_d = {32'd0, a_abs};
          end else begin
            m_d   = a_abs;
            acc_d = {32'd0, b_abs};
          end
        end
      end

      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = ST_FIXUP;
          end
        end
      end

      ST_FIXUP: begin
        state_d = ST_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            hi_d = prod_fix[63:32];
            lo_d = prod_fix[31:0];
          end else if (b_zero_q) begin
            // The iteration still runs on a zero divisor; its result is
            // simply discarded here.
            hi_d       = a_raw_q;
            lo_d       = 32'hFFFF_FFFF;
            div_zero_d = 1'b1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 5'd0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      b_zero_q   <= 1'b0;
      a_raw_q    <= 32'd0;
      m_q        <= 32'd0;
      acc_q      <= 64'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      b_zero_q   <= b_zero_d;
      a_raw_q    <= a_raw_d;
      m_q        <= m_d;
      acc_q      <= acc_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_muldiv_unit -- self-checking bench for muldiv_unit.
// Expected results come from plain 64-bit arithmetic on the operands; the
// bench also tracks the last committed hi/lo to check they hold when required.
// ---------------------------------------------------------------------------

`ifndef ALUOpWidth
`define ALUOpWidth 4
`endif
`ifndef Mult
`define Mult  4'd8
`endif
`ifndef Multu
`define Multu 4'd9
`endif
`ifndef Div
`define Div   4'd10
`endif
`ifndef Divu
`define Divu  4'd11
`endif

module tb_muldiv_unit;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   start = 1'b0;
  logic [`ALUOpWidth-1:0] op = '0;
  logic [31:0]            src_a = '0;
  logic [31:0]            src_b = '0;
  logic                   flush = 1'b0;
  logic                   busy;
  logic                   done;
  logic                   div_zero;
  logic [31:0]            hi;
  logic [31:0]            lo;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] m_hi = '0;   // last committed HI
  logic [31:0] m_lo = '0;   // last committed LO

  muldiv_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  // Reference behaviour from plain arithmetic.
  function automatic void model(input logic [`ALUOpWidth-1:0] o, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] h,
                                output logic [31:0] l, output logic dz);
    longint      p, q, r;
    logic [63:0] pu;
    dz = 1'b0;
    h  = '0;
    l  = '0;
    if (o == `Mult) begin
      p = longint'($signed(a)) * longint'($signed(b));
      h = p[63:32];
      l = p[31:0];
    end else if (o == `Multu) begin
      pu = {32'd0, a} * {32'd0, b};
      h  = pu[63:32];
      l  = pu[31:0];
    end else if (b == 32'd0) begin
      h  = a;
      l  = 32'hFFFF_FFFF;
      dz = 1'b1;
    end else if (o == `Div) begin
      q = longint'($signed(a)) / longint'($signed(b));
      r = longint'($signed(a)) % longint'($signed(b));
      l = q[31:0];
      h = r[31:0];
    end else begin
      l = a / b;
      h = a % b;
    end
  endfunction

  // Runs one operation starting in the current cycle; returns #1 after the
  // completion edge so the next call can start back to back.
  task automatic run_op(input logic [`ALUOpWidth-1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit disturb);
    logic [31:0] eh, el;
    logic        edz;
    bit          timing_bad;
    model(o, a, b, eh, el, edz);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    timing_bad = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      if (disturb && c >= 5 && c <= 20) begin
        start = 1'b1;
        op    = (c[0]) ? `Div : `Multu;
        src_a = $urandom;
        src_b = $urandom;
      end else begin
        start = 1'b0;
      end
      if (c < 33) begin
        if (busy !== 1'b1 || done !== 1'b0 || hi !== m_hi || lo !== m_lo) timing_bad = 1'b1;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    n_cmp++;
    if (timing_bad) begin
      n_err++;
      $display("FAIL timing op=%0d a=%08h b=%08h: busy/done/hi/lo wrong during run, required busy=1 done=0 hi/lo held", o, a, b);
    end
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL done_pulse: got done=%b busy=%b, required done=1 busy=0", done, busy);
    end
    n_cmp++;
    if (hi !== eh) begin
      n_err++;
      $display("FAIL hi op=%0d a=%08h b=%08h: got %08h required %08h", o, a, b, hi, eh);
    end
    n_cmp++;
    if (lo !== el) begin
      n_err++;
      $display("FAIL lo op=%0d a=%08h b=%08h: got %08h required %08h", o, a, b, lo, el);
    end
    n_cmp++;
    if (div_zero !== edz) begin
      n_err++;
      $display("FAIL div_zero op=%0d a=%08h b=%08h: got %b required %b", o, a, b, div_zero, edz);
    end
    m_hi = eh;
    m_lo = el;
    $display("op=%0d a=%08h b=%08h -> hi=%08h lo=%08h dz=%b done=%b", o, a, b, hi, lo, div_zero, done);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_err++;
      $display("FAIL reset_state: got busy=%b done=%b dz=%b hi=%08h lo=%08h, required all 0",
               busy, done, div_zero, hi, lo);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    m_hi = '0;
    m_lo = '0;
    $display("reset: busy=%b done=%b hi=%08h lo=%08h", busy, done, hi, lo);
  endtask

  task automatic test_directed();
    run_op(`Multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(`Mult,  32'hFFFF_FFFD, 32'd7,         1'b0);
    run_op(`Div,   32'hFFFF_FFF9, 32'd2,         1'b0);
    run_op(`Divu,  32'd100,       32'd0,         1'b0);
    run_op(`Div,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(`Mult,  32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(`Div,   32'd13,        32'hFFFF_FFFB, 1'b0);
    run_op(`Div,   32'hFFFF_FFF3, 32'd0,         1'b0);
  endtask

  // Consecutive run_op calls start in the done cycle, so this is a stream
  // of back-to-back operations with random operands and corner values.
  task automatic test_back_to_back();
    logic [`ALUOpWidth-1:0] ops [4];
    logic [31:0]            a, b;
    ops[0] = `Mult; ops[1] = `Multu; ops[2] = `Div; ops[3] = `Divu;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: a = 32'h8000_0000;
        2: b = 32'hFFFF_FFFF;
        3: b = $urandom_range(1, 15);
        default: ;
      endcase
      run_op(ops[$urandom_range(0, 3)], a, b, 1'b0);
    end
  endtask

  task automatic test_ignored_start();
    run_op(`Div,  32'hDEAD_BEEF, 32'h0000_1234, 1'b1);
    run_op(`Mult, 32'h1234_5678, 32'hFEDC_BA98, 1'b1);
  endtask

  task automatic test_invalid_op();
    start = 1'b1; op = 4'd0; src_a = 32'd5; src_b = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      n_err++;
      $display("FAIL invalid_op: got busy=%b hi=%08h lo=%08h, required busy=0 hi=%08h lo=%08h",
               busy, hi, lo, m_hi, m_lo);
    end
    $display("invalid op 0: busy=%b", busy);
  endtask

  task automatic test_flush();
    bit saw_done;
    // flush mid-CALC
    start = 1'b1; op = `Mult; src_a = 32'h0000_0123; src_b = 32'h0000_0456;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL flush_busy: got busy=%b required 0", busy);
    end
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done !== 1'b0 || div_zero !== 1'b0) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (saw_done) begin
      n_err++;
      $display("FAIL flush_done: done/div_zero pulsed after flush, required none");
    end
    n_cmp++;
    if (hi !== m_hi || lo !== m_lo) begin
      n_err++;
      $display("FAIL flush_hold: got hi=%08h lo=%08h required hi=%08h lo=%08h", hi, lo, m_hi, m_lo);
    end
    $display("flush in CALC: busy=%b hi=%08h lo=%08h", busy, hi, lo);
    // flush together with start in IDLE wins
    start = 1'b1; flush = 1'b1; op = `Divu; src_a = 32'd50; src_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL flush_start: got busy=%b required 0", busy);
    end
    $display("flush+start in IDLE: busy=%b", busy);
    // flush in FIXUP: no write, no done
    start = 1'b1; op = `Multu; src_a = 32'd3; src_b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (32) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      n_err++;
      $display("FAIL flush_fixup: got busy=%b done=%b hi=%08h lo=%08h required 0/0/%08h/%08h",
               busy, done, hi, lo, m_hi, m_lo);
    end
    $display("flush in FIXUP: busy=%b done=%b hi=%08h lo=%08h", busy, done, hi, lo);
  endtask

  task automatic test_reset_mid();
    start = 1'b1; op = `Divu; src_a = $urandom; src_b = 32'd77;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) begin
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b0;
    #1;
    m_hi = '0;
    m_lo = '0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_err++;
      $display("FAIL reset_mid: got busy=%b done=%b dz=%b hi=%08h lo=%08h, required all 0",
               busy, done, div_zero, hi, lo);
    end
    $display("reset mid divu: busy=%b hi=%08h lo=%08h", busy, hi, lo);
    @(posedge clk); #1;
    rst = 1'b1;
    run_op(`Divu, 32'd9, 32'd4, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_ignored_start();
    test_invalid_op();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
